// File: rtl/bcd_time_counter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_time_counter
// Purpose  : 1 Hz prescaler plus 24-hour BCD hh:mm:ss counter with manual
//            set mode (field select / increment).
// Revision : 1.0 - initial release
// ============================================================================
module bcd_time_counter #(
    parameter int DIV = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_mod,
    input  logic       set_next,
    input  logic       set_inc,
    output logic [7:0] hr,
    output logic [7:0] mn,
    output logic [7:0] sd,
    output logic [1:0] sel,
    output logic       sec_pulse,
    output logic       hour_pulse
);

    localparam int                c_PRESC_W   = $clog2(DIV);
    localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(DIV - 1);
    localparam logic [c_PRESC_W-1:0] c_PRESC_ONE = c_PRESC_W'(1);

    localparam logic [1:0] c_SEL_HR = 2'd0;
    localparam logic [1:0] c_SEL_MN = 2'd1;
    localparam logic [1:0] c_SEL_SD = 2'd2;

    typedef enum logic [0:0] {
        ST_RUN = 1'b0,
        ST_SET = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_PRESC_W-1:0]   r_presc;
    logic [7:0]             r_hr;
    logic [7:0]             r_mn;
    logic [7:0]             r_sd;
    logic [1:0]             r_sel;
    logic                   r_sec_pulse;
    logic                   r_hour_pulse;

    logic                   w_mode_change;
    logic                   w_tick;
    logic                   w_set_active;
    logic                   w_sd_wrap;
    logic                   w_mn_wrap;
    logic                   w_hr_wrap;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_RUN;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:  if (set_mod)  w_state_nxt = ST_SET;
            ST_SET:  if (!set_mod) w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // A mode change on the tick cycle suppresses that tick entirely.
    assign w_mode_change = (w_state_nxt != r_state);
    assign w_tick        = (r_state == ST_RUN) && !set_mod && (r_presc == c_PRESC_MAX);
    assign w_set_active  = (r_state == ST_SET) && set_mod;
    assign w_sd_wrap     = (r_sd == 8'h59);
    assign w_mn_wrap     = (r_mn == 8'h59);
    assign w_hr_wrap     = (r_hr == 8'h23);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc      <= '0;
            r_hr         <= 8'h00;
            r_mn         <= 8'h00;
            r_sd         <= 8'h00;
            r_sel        <= c_SEL_HR;
            r_sec_pulse  <= 1'b0;
            r_hour_pulse <= 1'b0;
        end else begin
            r_sec_pulse  <= w_tick;
            r_hour_pulse <= w_tick && w_sd_wrap && w_mn_wrap;

            if (w_mode_change || (r_state == ST_SET) || (r_presc == c_PRESC_MAX))
                r_presc <= '0;
            else
                r_presc <= r_presc + c_PRESC_ONE;

            if ((r_state == ST_RUN) && set_mod)
                r_sel <= c_SEL_HR;

            if (w_tick) begin
                r_sd <= w_sd_wrap ? 8'h00 : bcd_inc(r_sd);
                if (w_sd_wrap) begin
                    r_mn <= w_mn_wrap ? 8'h00 : bcd_inc(r_mn);
                    if (w_mn_wrap)
                        r_hr <= w_hr_wrap ? 8'h00 : bcd_inc(r_hr);
                end
            end else if (w_set_active) begin
                // Manual edits never carry; seconds are cleared to align to a reference.
                if (set_inc) begin
                    case (r_sel)
                        c_SEL_HR: r_hr <= w_hr_wrap ? 8'h00 : bcd_inc(r_hr);
                        c_SEL_MN: r_mn <= w_mn_wrap ? 8'h00 : bcd_inc(r_mn);
                        c_SEL_SD: r_sd <= 8'h00;
                        default:  ;
                    endcase
                end
                if (set_next)
                    r_sel <= (r_sel == c_SEL_SD) ? c_SEL_HR : r_sel + 2'd1;
            end
        end
    end

    assign hr         = r_hr;
    assign mn         = r_mn;
    assign sd         = r_sd;
    assign sel        = r_sel;
    assign sec_pulse  = r_sec_pulse;
    assign hour_pulse = r_hour_pulse;

endmodule
`default_nettype wire
